// File: rtl/i2c_fifo.sv
// Synchronous byte FIFO between the MCU register side and the I2C master FSM, with registered flags and a status byte.
// Optional sticky overflow/underflow flags are built when I2C_FIFO_ERR_FLAGS_EN is defined.
module i2c_fifo #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  i2c_core_clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_SIZE-1:0]  data_i,
  input  logic                  rd_en_i,
  output logic [DATA_SIZE-1:0]  data_o,
  output logic                  data_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic [7:0]            status_o
);

  localparam int                 DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_MAX    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

  logic [DATA_SIZE-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  overflow;
  logic                  underflow;

  // A push into a full FIFO is still legal when a pop frees a slot in the same cycle.
  assign rd_accept = rd_en_i & ~empty_o;
  assign wr_accept = wr_en_i & (~full_o | rd_accept);

  // NOTE: default assigned first so every path drives count_next and no latch is inferred.
  always_comb begin
    count_next = count;
    if (wr_accept && !rd_accept)      count_next = count + (ADDR_WIDTH + 1)'(1);
    else if (rd_accept && !wr_accept) count_next = count - (ADDR_WIDTH + 1)'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_o         <= '0;
      data_valid_o   <= 1'b0;
      empty_o        <= 1'b1;
      almost_empty_o <= 1'b1;
      full_o         <= 1'b0;
      almost_full_o  <= 1'b0;
    end else if (flush_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_valid_o   <= 1'b0;
      empty_o        <= 1'b1;
      almost_empty_o <= 1'b1;
      full_o         <= 1'b0;
      almost_full_o  <= 1'b0;
    end else begin
      data_valid_o <= rd_accept;
      if (wr_accept) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_accept) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        data_o <= mem[rd_ptr];
      end
      count          <= count_next;
      empty_o        <= (count_next == '0);
      full_o         <= (count_next == CNT_MAX);
      almost_full_o  <= (count_next >= AFULL_CNT);
      almost_empty_o <= (count_next <= AEMPTY_CNT);
    end
  end

  // NOTE: the storage array is deliberately left without reset; only pointers and count define contents.
  always_ff @(posedge i2c_core_clk_i) begin
    if (wr_accept && !reset_i && !flush_i) mem[wr_ptr] <= data_i;
  end

`ifdef I2C_FIFO_ERR_FLAGS_EN
  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i || flush_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en_i && full_o && !rd_accept) overflow  <= 1'b1;
      if (rd_en_i && empty_o)              underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign count_o  = count;
  assign status_o = {2'b00, underflow, overflow, almost_empty_o, almost_full_o, full_o, empty_o};

endmodule
